// File: rtl/npc_pkg.sv
// Shared constants for the next-PC predictor: counter encodings, reset PC,
// instruction size, and the saturating counter step.
package npc_pkg;

  localparam logic [1:0]  CNT_SNT    = 2'b00;
  localparam logic [1:0]  CNT_WNT    = 2'b01;
  localparam logic [1:0]  CNT_WT     = 2'b10;
  localparam logic [1:0]  CNT_ST     = 2'b11;

  localparam logic [31:0] PC_RESET   = 32'h0;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // One step of a 2-bit saturating counter toward taken or not-taken.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    end
    return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup
// on the fetch PC, synchronous update from EX (no read/write bypass).
module btb_table
  import npc_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_taken,
  output logic [31:0] rd_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic [31:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      cnt_q    [ENTRIES];
  logic            jump_q   [ENTRIES];

  logic [IDX-1:0]  rd_idx;
  logic [IDX-1:0]  up_idx;
  logic            rd_hit;
  logic            up_hit;

  // Instruction addresses are word aligned, so the low two bits never index.
  logic unused_lsbs;
  assign unused_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  assign rd_idx    = rd_pc[IDX+1:2];
  assign up_idx    = upd_pc[IDX+1:2];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[31:IDX+2]);
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[31:IDX+2]);
  assign rd_taken  = rd_hit && (jump_q[rd_idx] || cnt_q[rd_idx][1]);
  assign rd_target = target_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
        jump_q[i]   <= 1'b0;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_jump) begin
          cnt_q[up_idx]    <= CNT_ST;
          jump_q[up_idx]   <= 1'b1;
          target_q[up_idx] <= upd_target;
        end else begin
          cnt_q[up_idx] <= cnt_next(cnt_q[up_idx], upd_taken);
          if (upd_taken) begin
            target_q[up_idx] <= upd_target;
          end
        end
      end else if (upd_taken) begin
        // Miss on a taken instruction replaces whatever aliased into the slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= upd_pc[31:IDX+2];
        target_q[up_idx] <= upd_target;
        jump_q[up_idx]   <= upd_jump;
        cnt_q[up_idx]    <= upd_jump ? CNT_ST : CNT_WT;
      end
    end
  end

endmodule

// File: rtl/npc_predict.sv
// Next-PC generator: BTB prediction, EX misprediction redirect and pipeline flush.
// Define NPC_BTB_EN to build the BTB; without it every lookup predicts pc+4.
module npc_predict
  import npc_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] npc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush
);

  logic        ex_v;
  logic        mispredict;
  logic        lk_taken;
  logic [31:0] lk_target;

  // ex_valid only qualifies control-flow instructions; anything else in EX is ignored.
  assign ex_v = ex_valid && (ex_is_branch || ex_is_jump);

`ifdef NPC_BTB_EN
  btb_table #(.ENTRIES(ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_pc      (pc),
    .rd_taken   (lk_taken),
    .rd_target  (lk_target),
    .upd_en     (ex_v),
    .upd_pc     (ex_pc),
    .upd_taken  (ex_taken),
    .upd_jump   (ex_is_jump),
    .upd_target (ex_target)
  );
`else
  localparam int unused_entries = ENTRIES;
  logic unused_clk;
  assign unused_clk = clk;
  assign lk_taken   = 1'b0;
  assign lk_target  = pc + INST_BYTES;
`endif

  assign mispredict = !rst && ex_v &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign flush       = mispredict;
  assign pred_taken  = !rst && lk_taken;
  assign pred_target = rst        ? (PC_RESET + INST_BYTES) :
                       lk_taken   ? lk_target : (pc + INST_BYTES);

  always_comb begin
    npc = pred_target;
    if (rst) begin
      npc = PC_RESET;
    end else if (mispredict) begin
      npc = ex_taken ? ex_target : (ex_pc + INST_BYTES);
    end else if (stall) begin
      npc = pc;
    end
  end

endmodule

// File: tb/tb_npc_predict.sv
// Self-checking bench for npc_predict: directed scenarios plus random traffic
// against a table-level reference model; honours NPC_BTB_EN like the design.
module tb_npc_predict;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;
  localparam int W       = 66;
`ifdef NPC_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] pc, ex_pc, ex_target, ex_pred_target;
  logic        stall, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] npc, pred_target;
  logic        pred_taken, flush;

  npc_predict #(.ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .npc            (npc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // reference model: one record per BTB slot
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  bit          m_jump   [ENTRIES];

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic void model_lookup(input logic [31:0] a, output logic pt,
                                       output logic [31:0] tg);
    int s;
    s  = slot_of(a);
    pt = BTB_EN && m_valid[s] && (m_tag[s] == (a >> (IDX + 2))) &&
         (m_jump[s] || m_cnt[s] >= 2);
    tg = pt ? m_target[s] : a + 32'd4;
  endfunction

  function automatic void model_update();
    int s;
    bit hit;
    s   = slot_of(ex_pc);
    hit = m_valid[s] && (m_tag[s] == (ex_pc >> (IDX + 2)));
    if (hit && ex_is_jump) begin
      m_cnt[s] = 3; m_jump[s] = 1'b1; m_target[s] = ex_target;
    end else if (hit) begin
      if (ex_taken) begin
        if (m_cnt[s] < 3) m_cnt[s] = m_cnt[s] + 1;
        m_target[s] = ex_target;
      end else if (m_cnt[s] > 0) begin
        m_cnt[s] = m_cnt[s] - 1;
      end
    end else if (ex_taken) begin
      m_valid[s] = 1'b1; m_tag[s] = ex_pc >> (IDX + 2); m_target[s] = ex_target;
      m_jump[s]  = ex_is_jump; m_cnt[s] = ex_is_jump ? 3 : 2;
    end
  endfunction

  // driver: inputs are already set; push the expectation, then cross one edge
  task automatic step(input string nm);
    logic        pt, misp, exv;
    logic [31:0] ptg, e_npc;
    exv = ex_valid && (ex_is_branch || ex_is_jump);
    if (rst) begin
      model_reset();
      exp_q.push_back({32'h0, 1'b0, 32'h4, 1'b0});
    end else begin
      model_lookup(pc, pt, ptg);
      misp = exv && ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_target != ex_pred_target));
      if (misp)       e_npc = ex_taken ? ex_target : ex_pc + 32'd4;
      else if (stall) e_npc = pc;
      else            e_npc = ptg;
      exp_q.push_back({e_npc, pt, ptg, misp});
    end
    name_q.push_back(nm);
    @(posedge clk);
    if (!rst && exv && BTB_EN) model_update();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jp,
                        input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                        input logic ppt, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ppt; ex_pred_target = ptgt;
  endtask

  task automatic clr_ex();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0, 1, 2: return {$urandom_range(0, 63), 2'b00};
      3:       return 32'hFFFF_FFFC;
      default: return {$urandom_range(0, 7), 4'h0, 2'b00} + 32'h1000_0000;
    endcase
  endfunction

  // monitor: outputs are valid every cycle; check away from the active edge
  logic [W-1:0] mon_exp, mon_got;
  string        mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_got = {npc, pred_taken, pred_target, flush};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got npc=%h pred_taken=%b pred_target=%h flush=%b, expected npc=%h pred_taken=%b pred_target=%h flush=%b",
                 mon_nm, mon_got[65:34], mon_got[33], mon_got[32:1], mon_got[0],
                 mon_exp[65:34], mon_exp[33], mon_exp[32:1], mon_exp[0]);
      end
    end
  end

  logic        r_pt;
  logic [31:0] r_ptg;

  initial begin
    rst = 1'b1; pc = 32'h40; stall = 1'b0;
    clr_ex();
    model_reset();
    @(posedge clk); #1;

    step("rst_hold");
    step("rst_hold2");
    rst = 1'b0;
    step("rst_release");

    // allocate on a taken branch, then predict it
    pc = 32'h44;
    set_ex(1, 1, 0, 32'h10, 1, 32'h80, 0, 32'h0);
    step("alloc_flush");
    clr_ex(); pc = 32'h10;
    step("alloc_hit");

    // counter saturation at both ends
    set_ex(1, 1, 0, 32'h10, 0, 32'h0, 1, 32'h80);
    step("sat_nt1");
    step("sat_nt2");
    clr_ex();
    step("sat_at_00");
    set_ex(1, 1, 0, 32'h10, 0, 32'h0, 0, 32'h0);
    step("sat_nt3");
    step("sat_nt4");
    clr_ex();
    step("sat_hold_00");
    set_ex(1, 1, 0, 32'h10, 1, 32'h80, 0, 32'h0);
    step("sat_t1");
    step("sat_t2");
    step("sat_t3");
    step("sat_t4");
    set_ex(1, 1, 0, 32'h10, 0, 32'h0, 1, 32'h80);
    step("sat_nt_from_11");
    clr_ex();
    step("sat_still_taken");

    // stall versus flush
    stall = 1'b1; pc = 32'h30;
    step("stall_hold");
    set_ex(1, 1, 0, 32'h20, 0, 32'h0, 1, 32'h60);
    step("stall_flush");
    stall = 1'b0; clr_ex();

    // aliasing between two PCs sharing a slot
    set_ex(1, 0, 1, 32'h10, 1, 32'h200, 0, 32'h0);
    step("alias_jump_a");
    set_ex(1, 0, 1, 32'h50, 1, 32'h300, 0, 32'h0);
    step("alias_jump_b");
    clr_ex(); pc = 32'h10;
    step("alias_miss");
    pc = 32'h50;
    step("alias_hit");

    // EX valid without branch/jump is ignored; repeated allocate; reset drops update
    set_ex(1, 0, 0, 32'h60, 1, 32'h999, 0, 32'h0);
    step("ignored_ex");
    set_ex(1, 1, 0, 32'h18, 1, 32'h40, 0, 32'h0);
    pc = 32'h18;
    step("realloc_pass1");
    step("realloc_pass2");
    clr_ex(); pc = 32'hFFFF_FFFC;
    step("pc_wrap");
    set_ex(1, 0, 1, 32'h70, 1, 32'h500, 0, 32'h0);
    rst = 1'b1;
    step("rst_midop");
    rst = 1'b0; clr_ex(); pc = 32'h70;
    step("rst_dropped_update");

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      pc           = pick();
      stall        = ($urandom_range(0, 3) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_is_jump   = ($urandom_range(0, 3) == 0);
      ex_is_branch = !ex_is_jump && ($urandom_range(0, 7) != 0);
      ex_pc        = pick();
      ex_taken     = ex_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      ex_target    = pick();
      if ($urandom_range(0, 1) == 1) begin
        model_lookup(ex_pc, r_pt, r_ptg);
        ex_pred_taken  = r_pt;
        ex_pred_target = r_ptg;
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = pick();
      end
      step("random");
    end

    rst = 1'b0; clr_ex();
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_predict.md
# npc_predict

Next-PC generator for the pipelined RISC-V core, sitting directly upstream of the PC register. Each cycle it turns the current fetch PC into the next PC from a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It accepts branch/jump resolution from EX, detects mispredictions and redirects fetch. It also raises a flush pulse for the IF/ID and ID/EX registers.

## Interface
Parameters:
- ENTRIES, 16, BTB depth; power of two, 4..256; IDX = log2(ENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current fetch PC (PC register output)
- stall  in  1  hazard hold; next PC = pc
- ex_valid  in  1  EX holds a valid control-flow instruction this cycle
- ex_is_branch  in  1  conditional branch (B-type)
- ex_is_jump  in  1  jal/jalr
- ex_pc  in  32  PC of the EX instruction
- ex_taken  in  1  resolved direction (1 for jumps)
- ex_target  in  32  resolved target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  32  predicted target carried down the pipe
- npc  out  32  next PC to the PC register
- pred_taken  out  1  prediction for the instruction at pc
- pred_target  out  32  predicted target for the instruction at pc
- flush  out  1  misprediction; kill IF/ID and ID/EX contents

## Operation
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Entry fields: valid, tag, target[31:0], cnt[1:0], jump.
- Hit = valid && tag match. pred_taken = hit && (jump || cnt[1]). pred_target = pred_taken ? target : pc+4 (32-bit wrap).
- mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- npc priority:
  - rst: 0.
  - mispredict: ex_taken ? ex_target : ex_pc+4.
  - stall: pc.
  - otherwise: pred_target.
- flush = mispredict. Flush overrides stall.
- Update occurs on each posedge where ex_valid && (ex_is_branch || ex_is_jump), indexed by ex_pc. Update is independent of stall.
  - Hit, branch: cnt saturating +1 if taken, -1 if not taken. Target is rewritten if taken.
  - Hit, jump: cnt = 11, jump = 1, target rewritten.
  - Miss, taken: allocate (replace) with valid = 1, tag, target, jump = ex_is_jump, cnt = jump ? 11 : 10.
  - Miss, not taken: no write.
- Counter states: SNT 00, WNT 01, WT 10, ST 11. Saturation holds at 00 and 11.

## Timing
- Prediction path (pc to npc/pred_*) is purely combinational, zero latency.
- Table writes are synchronous. A same-cycle read of the entry being written returns the old contents; there is no bypass.
- Reset asynchronously clears all valid bits and sets cnt = 01. While rst is asserted: npc = 0, pred_taken = 0, pred_target = 4, flush = 0.
- After reset release, all lookups miss, so npc = pc+4 until the first taken update.
- Redirect takes effect at the next clock edge. flush is asserted for exactly the cycle in which mispredict is true.
- rst asserted mid-operation drops any pending update.
- ex_valid && !ex_is_branch && !ex_is_jump is ignored; ex_valid is gated to 0 internally.

## Configuration
- NPC_BTB_EN defined: BTB and counters are instantiated as described above.
- NPC_BTB_EN undefined: no storage. pred_taken = 0 and pred_target = pc+4, so every taken branch or jump mispredicts and redirects. Ports are unchanged; ENTRIES is ignored.

## Structure
- Shared package npc_pkg holds:
  - counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST;
  - PC_RESET = 32'h0;
  - INST_BYTES = 4.
- One sub-module, btb_table: storage, asynchronous reset, combinational lookup, and the update/saturation logic. npc_predict holds the mispredict compare and the npc mux.

## Test plan
- Reset: hold rst with pc = 32'h40 → npc = 0, flush = 0. Release rst → npc = 32'h44, pred_taken = 0.
- Allocate: a taken branch resolves with ex_pc = 32'h10, ex_target = 32'h80, ex_pred_taken = 0 → flush = 1, npc = 32'h80. Next cycle pc = 32'h10 → pred_taken = 1, npc = 32'h80.
- Saturation:
  - After allocation (cnt = 10), two not-taken resolves at 32'h10 → cnt 01 then 00, so pc = 32'h10 predicts 32'h14.
  - Two more not-taken resolves keep cnt at 00.
  - Three taken resolves take cnt to 11, and it stays there.
- Stall vs. flush: stall = 1 with no mispredict → npc = pc. stall = 1 with a not-taken mispredict at ex_pc = 32'h20 → npc = 32'h24, flush = 1.
- Aliasing (ENTRIES = 16): a taken jump at 32'h10 (target 32'h200), then a taken jump at 32'h50 (same index, target 32'h300) → lookup at 32'h10 misses, lookup at 32'h50 predicts 32'h300.
- Macro off: compile without NPC_BTB_EN and repeat the allocate scenario twice → flush on both passes, pred_taken always 0.
